// File: rtl/fill_ar_arbiter_pkg.sv
// Shared types and helpers for the fill-read AR arbiter.
// The ID helpers work on a fixed 32-bit container. Callers cast the
// arguments in and the result back to their own widths.
package fill_ar_arbiter_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

    localparam int DEF_MAX_OUTST = 8;
    localparam int OUTST_DBG_W   = 4;
    localparam int ID_FN_W       = 32;

    // Low src_w bits of an ID carry the requester index; the rest is the fixed base.
    function automatic logic [ID_FN_W-1:0] id_src_mask(input int src_w);
        return (ID_FN_W'(1) << src_w) - ID_FN_W'(1);
    endfunction

    function automatic logic [ID_FN_W-1:0] arid_compose(
        input logic [ID_FN_W-1:0] base,
        input logic [ID_FN_W-1:0] src,
        input int                 src_w
    );
        logic [ID_FN_W-1:0] mask;
        mask = id_src_mask(src_w);
        return (base & ~mask) | (src & mask);
    endfunction

    function automatic logic rid_base_match(
        input logic [ID_FN_W-1:0] rid,
        input logic [ID_FN_W-1:0] base,
        input int                 src_w
    );
        return (rid >> src_w) == (base >> src_w);
    endfunction

    function automatic logic [ID_FN_W-1:0] rid_src(
        input logic [ID_FN_W-1:0] rid,
        input int                 src_w
    );
        return rid & id_src_mask(src_w);
    endfunction

endpackage

// File: rtl/fill_ar_arbiter_rr_arbiter.sv
// Round-robin picker: the first eligible source at or after the pointer, wrapping.
// The grant is one-hot. The source count is a power of two, so the index wraps naturally.
module rr_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_elig,
    input  logic [SRC_W-1:0]   i_ptr,
    output logic [NUM_SRC-1:0] o_gnt,
    output logic [SRC_W-1:0]   o_gnt_idx,
    output logic               o_any_gnt
);

    // Scan the sources starting at the pointer and grant the first eligible one.
    always_comb begin
        logic [SRC_W-1:0] v_idx;
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any_gnt = 1'b0;
        v_idx     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            v_idx = i_ptr + SRC_W'(k);
            if (!o_any_gnt && i_elig[v_idx]) begin
                o_any_gnt    = 1'b1;
                o_gnt_idx    = v_idx;
                o_gnt[v_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fill_ar_arbiter.sv
// Arbitrates the fill-read requesters onto a single AXI AR channel.
// Each source has a credit limit on reads in flight. Credits are returned
// by snooping the last beat of each R burst.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no AR held; a round-robin pick among eligible sources is accepted
// S_ISSUE | AR beat held stable with arvalid_o=1 until arready_i
module fill_ar_arbiter
    import fill_ar_arbiter_pkg::*;
#(
    parameter int                  NUM_SRC    = 2,
    parameter int                  SRC_W      = $clog2(NUM_SRC),
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  ID_WIDTH   = 4,
    parameter logic [ID_WIDTH-1:0] ID_BASE    = ID_WIDTH'('hA),
    parameter int                  TID_WIDTH  = 8,
    parameter int                  MAX_OUTST  = DEF_MAX_OUTST
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_SRC-1:0]              req_valid_i,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_SRC*TID_WIDTH-1:0]    req_tid_i,
    output logic [NUM_SRC-1:0]              req_ready_o,
    output logic [ID_WIDTH-1:0]             arid_o,
    output logic [ADDR_WIDTH-1:0]           araddr_o,
    output logic [TID_WIDTH-1:0]            artid_o,
    output logic                            arvalid_o,
    input  logic                            arready_i,
    input  logic [ID_WIDTH-1:0]             rid_i,
    input  logic                            rvalid_i,
    input  logic                            rready_i,
    input  logic                            rlast_i,
    output logic [NUM_SRC*OUTST_DBG_W-1:0]  outst_o
);

    localparam int               CNT_W   = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
    localparam logic [31:0]      BASE32  = 32'(ID_BASE);

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [SRC_W-1:0]        r_ptr;
    logic [SRC_W-1:0]        r_src;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [TID_WIDTH-1:0]    r_tid;
    logic [CNT_W-1:0]        r_cnt [NUM_SRC];

    logic [NUM_SRC-1:0]      w_elig;
    logic [NUM_SRC-1:0]      w_gnt;
    logic [SRC_W-1:0]        w_gnt_idx;
    logic                    w_any_gnt;
    logic                    w_accept;
    logic                    w_r_fire;
    logic [SRC_W-1:0]        w_r_src;
    logic [NUM_SRC-1:0]      w_inc;
    logic [NUM_SRC-1:0]      w_dec;
    logic                    w_dec_underflow;

    // A source may compete only while it has credit left. This also covers the beat still being held.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_elig[i] = req_valid_i[i] && (r_cnt[i] < CNT_MAX);
        end
    end

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr (
        .i_elig    (w_elig),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any_gnt (w_any_gnt)
    );

    // Decode the R last-beat snoop. Beats whose ID belongs to another master are ignored.
    always_comb begin
        w_r_fire = rvalid_i && rready_i && rlast_i &&
                   rid_base_match(32'(rid_i), BASE32, SRC_W);
        w_r_src  = SRC_W'(rid_src(32'(rid_i), SRC_W));
    end

    // Next-state and handshake outputs. A request is accepted only while no AR is held.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready_o = '0;
        arvalid_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = w_gnt;
                if (w_any_gnt) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                arvalid_o = 1'b1;
                if (arready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register. Reset drops any AR that is being held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // AR holding register and round-robin pointer, loaded on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_src  <= '0;
            r_addr <= '0;
            r_tid  <= '0;
        end else if (w_accept) begin
            r_ptr  <= w_gnt_idx + SRC_W'(1);
            r_src  <= w_gnt_idx;
            r_addr <= req_addr_i[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            r_tid  <= req_tid_i[w_gnt_idx*TID_WIDTH +: TID_WIDTH];
        end
    end

    // Per-source credit events. A decrement at zero is dropped so the counter saturates.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_inc[i] = w_accept && (w_gnt_idx == SRC_W'(i));
            w_dec[i] = w_r_fire && (w_r_src == SRC_W'(i)) && (r_cnt[i] != '0);
        end
        w_dec_underflow = w_r_fire && (r_cnt[w_r_src] == '0);
    end

    // Credit counters. A take and a return on the same source in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // A returned last beat with no read outstanding points to a broken requester or slave.
    credit_underflow: assert property (@(posedge clk) disable iff (!rst_n) !w_dec_underflow);

    assign arid_o   = ID_WIDTH'(arid_compose(BASE32, 32'(r_src), SRC_W));
    assign araddr_o = r_addr;
    assign artid_o  = r_tid;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_outst
        assign outst_o[g*OUTST_DBG_W +: OUTST_DBG_W] = OUTST_DBG_W'(r_cnt[g]);
    end

endmodule
